// File: rtl/mcu_ctrl.sv
// Master control FSM for the edge-detection pipeline: sequences pixel reads, grayscale,
// buffer-1 saves, gradient, buffer-2 saves and result writes, and owns both bus addresses.
module mcu_ctrl #(
    parameter logic [31:0] RADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0] WADDR_BASE   = 32'h0010_0000,
    parameter logic [31:0] ADDR_STEP    = 32'd4,
    parameter logic [31:0] TOTAL_BLOCKS = 32'd40003
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_stop,
    input  logic        i_read_complete,
    input  logic        i_grayscale_data_ready,
    input  logic        i_b1_full,
    input  logic        i_gradient_data_ready,
    input  logic        i_start_next_write,
    input  logic        i_write_complete,
    input  logic        i_b2_empty,
    output logic [31:0] o_mcu_raddr,
    output logic        o_re,
    output logic        o_grayscale_start,
    output logic        o_b1_save,
    output logic        o_gradient_start,
    output logic        o_b2_save,
    output logic [31:0] o_mcu_waddr,
    output logic        o_we,
    output logic        o_complete
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD     = 4'd1;
    localparam logic [3:0] S_GRAY   = 4'd2;
    localparam logic [3:0] S_GWAIT  = 4'd3;
    localparam logic [3:0] S_SAVE1  = 4'd4;
    localparam logic [3:0] S_GSTART = 4'd5;
    localparam logic [3:0] S_DWAIT  = 4'd6;
    localparam logic [3:0] S_SAVE2  = 4'd7;
    localparam logic [3:0] S_WIDLE  = 4'd8;
    localparam logic [3:0] S_WR     = 4'd9;
    localparam logic [3:0] S_DONE   = 4'd10;

    logic [3:0]  state_q, state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic [31:0] blk_cnt_inc;

    assign blk_cnt_inc = blk_cnt_q + 32'd1;

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        blk_cnt_d = blk_cnt_q;
        if (i_stop) begin
            state_d   = S_IDLE;
            raddr_d   = RADDR_BASE;
            waddr_d   = WADDR_BASE;
            blk_cnt_d = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RD;
                S_RD: begin
                    // A full window must be processed before any further pixel is fetched.
                    if (i_b1_full) begin
                        state_d = S_GSTART;
                    end else if (i_read_complete) begin
                        state_d = S_GRAY;
                        raddr_d = raddr_q + ADDR_STEP;
                    end
                end
                S_GRAY:   state_d = S_GWAIT;
                S_GWAIT:  if (i_grayscale_data_ready) state_d = S_SAVE1;
                S_SAVE1:  state_d = S_RD;
                S_GSTART: state_d = S_DWAIT;
                S_DWAIT:  if (i_gradient_data_ready) state_d = S_SAVE2;
                S_SAVE2:  state_d = S_WIDLE;
                S_WIDLE: begin
                    if (i_b2_empty) begin
                        blk_cnt_d = blk_cnt_inc;
                        state_d   = (blk_cnt_inc == TOTAL_BLOCKS) ? S_DONE : S_RD;
                    end else if (i_start_next_write) begin
                        state_d = S_WR;
                    end
                end
                S_WR: begin
                    if (i_write_complete) begin
                        state_d = S_WIDLE;
                        waddr_d = waddr_q + ADDR_STEP;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            raddr_q   <= RADDR_BASE;
            waddr_q   <= WADDR_BASE;
            blk_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Moore outputs: each strobe state is left after one cycle, so strobes are 1 clk wide.
    assign o_mcu_raddr       = raddr_q;
    assign o_mcu_waddr       = waddr_q;
    assign o_re              = (state_q == S_RD);
    assign o_grayscale_start = (state_q == S_GRAY);
    assign o_b1_save         = (state_q == S_SAVE1);
    assign o_gradient_start  = (state_q == S_GSTART);
    assign o_b2_save         = (state_q == S_SAVE2);
    assign o_we              = (state_q == S_WR);
    assign o_complete        = (state_q == S_DONE);

endmodule

// File: tb/tb_mcu_ctrl.sv
// Scoreboard bench for mcu_ctrl: every strobe, write start and completion is popped
// against an expected event (kind + address) pushed when the stimulus was driven.
module tb_mcu_ctrl;

    localparam logic [31:0] RBASE = 32'h0000_0000;
    localparam logic [31:0] WBASE = 32'h0010_0000;
    localparam logic [31:0] STEP  = 32'd4;

    localparam logic [2:0] EV_GRAY  = 3'd1;
    localparam logic [2:0] EV_SAVE1 = 3'd2;
    localparam logic [2:0] EV_GRAD  = 3'd3;
    localparam logic [2:0] EV_SAVE2 = 3'd4;
    localparam logic [2:0] EV_WE    = 3'd5;
    localparam logic [2:0] EV_DONE  = 3'd6;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_stop, i_read_complete, i_grayscale_data_ready, i_b1_full;
    logic        i_gradient_data_ready, i_start_next_write, i_write_complete, i_b2_empty;
    logic [31:0] o_mcu_raddr, o_mcu_waddr;
    logic        o_re, o_grayscale_start, o_b1_save, o_gradient_start, o_b2_save;
    logic        o_we, o_complete;

    int          n_checks = 0;
    int          n_errors = 0;
    ev_t         sb_q[$];
    logic [31:0] exp_raddr, exp_waddr;
    logic        we_prev   = 1'b0;
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;

    mcu_ctrl #(
        .RADDR_BASE  (RBASE),
        .WADDR_BASE  (WBASE),
        .ADDR_STEP   (STEP),
        .TOTAL_BLOCKS(32'd2)
    ) dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_stop                (i_stop),
        .i_read_complete       (i_read_complete),
        .i_grayscale_data_ready(i_grayscale_data_ready),
        .i_b1_full             (i_b1_full),
        .i_gradient_data_ready (i_gradient_data_ready),
        .i_start_next_write    (i_start_next_write),
        .i_write_complete      (i_write_complete),
        .i_b2_empty            (i_b2_empty),
        .o_mcu_raddr           (o_mcu_raddr),
        .o_re                  (o_re),
        .o_grayscale_start     (o_grayscale_start),
        .o_b1_save             (o_b1_save),
        .o_gradient_start      (o_gradient_start),
        .o_b2_save             (o_b2_save),
        .o_mcu_waddr           (o_mcu_waddr),
        .o_we                  (o_we),
        .o_complete            (o_complete)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [2:0] kind, input logic [31:0] addr);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        sb_q.push_back(e);
    endfunction

    task automatic sb_compare(input logic [2:0] kind, input logic [31:0] addr);
        ev_t e;
        $display("txn kind=%0d addr=%08h", kind, addr);
        if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(kind), 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_kind", 32'(kind), 32'(e.kind));
            check("sb_addr", addr, e.addr);
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (o_grayscale_start)       sb_compare(EV_GRAY,  o_mcu_raddr);
            if (o_b1_save)               sb_compare(EV_SAVE1, o_mcu_raddr);
            if (o_gradient_start)        sb_compare(EV_GRAD,  o_mcu_raddr);
            if (o_b2_save)               sb_compare(EV_SAVE2, o_mcu_raddr);
            if (o_we && !we_prev)        sb_compare(EV_WE,    o_mcu_waddr);
            if (o_complete && !done_prev) sb_compare(EV_DONE, o_mcu_raddr);
        end
        we_prev   <= o_we;
        done_prev <= o_complete;
    end

    task automatic wait_re();
        int n = 0;
        while (o_re !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_re", 32'(o_re), 32'd1);
    endtask

    task automatic fill_pass(input bit stray_read);
        wait_re();
        exp_raddr = exp_raddr + STEP;
        push(EV_GRAY, exp_raddr);
        push(EV_SAVE1, exp_raddr);
        i_read_complete = 1'b1;
        @(negedge clk);
        i_read_complete = 1'b0;
        @(negedge clk);
        if (stray_read) begin
            // A read pulse during GWAIT must be dropped, not queued.
            i_read_complete = 1'b1;
            @(negedge clk);
            i_read_complete = 1'b0;
        end
        i_grayscale_data_ready = 1'b1;
        @(negedge clk);
        i_grayscale_data_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic grad_phase();
        wait_re();
        push(EV_GRAD, exp_raddr);
        push(EV_SAVE2, exp_raddr);
        i_b1_full       = 1'b1;
        i_read_complete = 1'b1;
        @(negedge clk);
        i_b1_full       = 1'b0;
        i_read_complete = 1'b0;
        check("raddr_hold_b1_full", o_mcu_raddr, exp_raddr);
        @(negedge clk);
        i_grayscale_data_ready = 1'b1;
        @(negedge clk);
        i_grayscale_data_ready = 1'b0;
        i_gradient_data_ready  = 1'b1;
        @(negedge clk);
        i_gradient_data_ready  = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_pass();
        push(EV_WE, exp_waddr);
        i_start_next_write = 1'b1;
        @(negedge clk);
        i_start_next_write = 1'b0;
        check("we_in_wr", 32'(o_we), 32'd1);
        @(negedge clk);
        i_write_complete = 1'b1;
        @(negedge clk);
        i_write_complete = 1'b0;
        check("we_after_wc", 32'(o_we), 32'd0);
        exp_waddr = exp_waddr + STEP;
    endtask

    task automatic run_block(input bit expect_done);
        for (int i = 0; i < 25; i++) fill_pass(i == 3);
        check("raddr_after_fill", o_mcu_raddr, exp_raddr);
        grad_phase();
        for (int i = 0; i < 9; i++) drain_pass();
        check("waddr_after_drain", o_mcu_waddr, exp_waddr);
        if (expect_done) push(EV_DONE, exp_raddr);
        i_b2_empty = 1'b1;
        @(negedge clk);
        i_b2_empty = 1'b0;
        check("complete_after_block", 32'(o_complete), 32'(expect_done));
        check("re_after_block", 32'(o_re), 32'(!expect_done));
        if (expect_done) begin
            repeat (3) @(negedge clk);
            check("complete_held", 32'(o_complete), 32'd1);
            check("re_stays_low", 32'(o_re), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        {i_stop, i_read_complete, i_grayscale_data_ready, i_b1_full} = '0;
        {i_gradient_data_ready, i_start_next_write, i_write_complete, i_b2_empty} = '0;
        repeat (3) @(negedge clk);
        check("rst_raddr", o_mcu_raddr, RBASE);
        check("rst_waddr", o_mcu_waddr, WBASE);
        check("rst_strobes", 32'({o_re, o_grayscale_start, o_b1_save, o_gradient_start,
                                  o_b2_save, o_we, o_complete}), 32'd0);
        n_rst = 1'b1;
        check("idle_re", 32'(o_re), 32'd0);
        @(negedge clk);
        check("rd_re", 32'(o_re), 32'd1);
        exp_raddr = RBASE;
        exp_waddr = WBASE;

        run_block(1'b0);
        run_block(1'b1);

        // Abort out of DONE.
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("stop_done_complete", 32'(o_complete), 32'd0);
        check("stop_done_raddr", o_mcu_raddr, RBASE);
        check("stop_done_waddr", o_mcu_waddr, WBASE);
        exp_raddr = RBASE;
        exp_waddr = WBASE;

        // Abort while waiting for grayscale.
        wait_re();
        exp_raddr = exp_raddr + STEP;
        push(EV_GRAY, exp_raddr);
        i_read_complete = 1'b1;
        @(negedge clk);
        i_read_complete = 1'b0;
        @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("stop_gwait_re", 32'(o_re), 32'd0);
        check("stop_gwait_raddr", o_mcu_raddr, RBASE);
        check("stop_gwait_waddr", o_mcu_waddr, WBASE);
        check("stop_gwait_complete", 32'(o_complete), 32'd0);
        exp_raddr = RBASE;
        @(negedge clk);
        check("stop_gwait_rd", 32'(o_re), 32'd1);

        run_block(1'b0);

        // Asynchronous reset in the middle of a write.
        for (int i = 0; i < 25; i++) fill_pass(1'b0);
        grad_phase();
        push(EV_WE, exp_waddr);
        i_start_next_write = 1'b1;
        @(negedge clk);
        i_start_next_write = 1'b0;
        check("we_before_rst", 32'(o_we), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_wr_we", 32'(o_we), 32'd0);
        check("rst_wr_raddr", o_mcu_raddr, RBASE);
        check("rst_wr_waddr", o_mcu_waddr, WBASE);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_wr_rd", 32'(o_re), 32'd1);
        check("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
